// File: rtl/bus_gate_ctrl.sv
// Registered gated-source bus multiplexer. Checks that the gates are one-hot,
// resolves contention by lowest index, and reports ownership and conflict history.
module bus_gate_ctrl #(
   parameter int WIDTH       = 16,
   parameter int NUM_SRC     = 4,
   parameter int HOLD_IDLE   = 1,
   parameter int DEFAULT_SRC = 0,
   parameter int CNT_W       = 8
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic [NUM_SRC*WIDTH-1:0]   src_data,
   input  logic [NUM_SRC-1:0]         gate,
   input  logic                       clear_err,
   output logic [WIDTH-1:0]           Q,
   output logic                       bus_valid,
   output logic [$clog2(NUM_SRC)-1:0] owner,
   output logic                       handover,
   output logic                       conflict,
   output logic                       conflict_sticky,
   output logic [CNT_W-1:0]           conflict_count
);

   localparam int OW   = $clog2(NUM_SRC);
   localparam int PW   = $clog2(NUM_SRC + 1);
   localparam int DSRC = (DEFAULT_SRC < NUM_SRC) ? DEFAULT_SRC : 0;

   typedef enum logic [1:0] {
      CLS_IDLE     = 2'd0,
      CLS_DRIVE    = 2'd1,
      CLS_CONFLICT = 2'd2
   } cls_e;

   generate
      if (DEFAULT_SRC < 0 || DEFAULT_SRC >= NUM_SRC) begin : g_bad_default
         $error("bus_gate_ctrl: DEFAULT_SRC out of range");
      end
      if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
         $error("bus_gate_ctrl: NUM_SRC must be 2..16");
      end
   endgenerate

   logic [WIDTH-1:0] q_q, q_d;
   logic             valid_q, valid_d;
   logic [OW-1:0]    owner_q, owner_d;
   logic             ho_q, ho_d;
   logic             conf_q, conf_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [PW-1:0]    n_hot_s;
   logic [OW-1:0]    low_idx_s;
   logic [WIDTH-1:0] sel_data_s;
   cls_e             cls_s;

   // Popcount of the gates and lowest asserted index (scanned high to low so the lowest wins).
   always_comb begin
      n_hot_s    = '0;
      low_idx_s  = '0;
      sel_data_s = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (gate[i]) begin
            n_hot_s    = n_hot_s + PW'(1);
            low_idx_s  = OW'(i);
            sel_data_s = src_data[i*WIDTH +: WIDTH];
         end else begin
            n_hot_s    = n_hot_s;
         end
      end
      if (n_hot_s == PW'(0)) begin
         cls_s = CLS_IDLE;
      end else if (n_hot_s == PW'(1)) begin
         cls_s = CLS_DRIVE;
      end else begin
         cls_s = CLS_CONFLICT;
      end
   end

   // Next-state: clear_err is applied first so a same-cycle conflict is recorded after it.
   always_comb begin
      q_d      = q_q;
      valid_d  = 1'b0;
      owner_d  = owner_q;
      ho_d     = 1'b0;
      conf_d   = 1'b0;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      if (clear_err) begin
         sticky_d = 1'b0;
         cnt_d    = '0;
      end else begin
         sticky_d = sticky_q;
         cnt_d    = cnt_q;
      end
      case (cls_s)
         CLS_IDLE: begin
            if (HOLD_IDLE == 0) begin
               q_d     = src_data[DSRC*WIDTH +: WIDTH];
               owner_d = OW'(DSRC);
            end else begin
               q_d     = q_q;
               owner_d = owner_q;
            end
         end
         CLS_DRIVE, CLS_CONFLICT: begin
            q_d     = sel_data_s;
            owner_d = low_idx_s;
            valid_d = 1'b1;
            ho_d    = valid_q && (low_idx_s != owner_q);
            if (cls_s == CLS_CONFLICT) begin
               conf_d   = 1'b1;
               sticky_d = 1'b1;
               if (cnt_d != {CNT_W{1'b1}}) begin
                  cnt_d = cnt_d + CNT_W'(1);
               end else begin
                  cnt_d = cnt_d;
               end
            end else begin
               conf_d = 1'b0;
            end
         end
         default: begin
            q_d     = q_q;
            owner_d = owner_q;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         q_q      <= '0;
         valid_q  <= 1'b0;
         owner_q  <= '0;
         ho_q     <= 1'b0;
         conf_q   <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         q_q      <= q_d;
         valid_q  <= valid_d;
         owner_q  <= owner_d;
         ho_q     <= ho_d;
         conf_q   <= conf_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign Q               = q_q;
   assign bus_valid       = valid_q;
   assign owner           = owner_q;
   assign handover        = ho_q;
   assign conflict        = conf_q;
   assign conflict_sticky = sticky_q;
   assign conflict_count  = cnt_q;

endmodule

// File: tb/tb_bus_gate_ctrl.sv
// Directed bench for bus_gate_ctrl: dut_a holds on idle with a 2-bit counter,
// dut_b loads source 0 on idle with the default 8-bit counter.
module tb_bus_gate_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [63:0] src_data;
   logic [3:0]  gate;
   logic        clear_err;

   logic [15:0] q_a, q_b;
   logic        v_a, v_b, ho_a, ho_b, cf_a, cf_b, st_a, st_b;
   logic [1:0]  o_a, o_b;
   logic [1:0]  cnt_a;
   logic [7:0]  cnt_b;

   logic [15:0] pc, mdr, mar, alu;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [15:0] q;
      logic        v;
      logic [1:0]  o;
      logic        ho;
      logic        cf;
      logic        st;
      logic [1:0]  cnt;
      logic        chk_b;
      logic [15:0] qb;
      logic [1:0]  ob;
   } exp_t;

   exp_t sb[$];

   always #5 Clk = ~Clk;

   assign src_data = {alu, mar, mdr, pc};

   bus_gate_ctrl #(.WIDTH(16), .NUM_SRC(4), .HOLD_IDLE(1), .DEFAULT_SRC(0), .CNT_W(2)) dut_a (
      .Clk(Clk), .Reset(Reset), .src_data(src_data), .gate(gate), .clear_err(clear_err),
      .Q(q_a), .bus_valid(v_a), .owner(o_a), .handover(ho_a), .conflict(cf_a),
      .conflict_sticky(st_a), .conflict_count(cnt_a)
   );

   bus_gate_ctrl #(.WIDTH(16), .NUM_SRC(4), .HOLD_IDLE(0), .DEFAULT_SRC(0), .CNT_W(8)) dut_b (
      .Clk(Clk), .Reset(Reset), .src_data(src_data), .gate(gate), .clear_err(clear_err),
      .Q(q_b), .bus_valid(v_b), .owner(o_b), .handover(ho_b), .conflict(cf_b),
      .conflict_sticky(st_b), .conflict_count(cnt_b)
   );

   task automatic chk(input string tag, input int stp, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL step%0d %s observed=%0h expected=%0h", stp, tag, obs, exp);
      end
   endtask

   // Drive one cycle, queue its expectation, then compare #1 after the edge.
   task automatic step(input int stp, input logic rst, input logic [3:0] g, input logic clr,
                       input logic [15:0] q, input logic v, input logic [1:0] o, input logic ho,
                       input logic cf, input logic st, input logic [1:0] cnt,
                       input logic chk_b, input logic [15:0] qb, input logic [1:0] ob);
      exp_t e;
      Reset     = rst;
      gate      = g;
      clear_err = clr;
      e.q = q; e.v = v; e.o = o; e.ho = ho; e.cf = cf; e.st = st; e.cnt = cnt;
      e.chk_b = chk_b; e.qb = qb; e.ob = ob;
      sb.push_back(e);
      @(posedge Clk);
      #1;
      e = sb.pop_front();
      chk("Q",        stp, 32'(q_a),   32'(e.q));
      chk("bus_valid",stp, 32'(v_a),   32'(e.v));
      chk("owner",    stp, 32'(o_a),   32'(e.o));
      chk("handover", stp, 32'(ho_a),  32'(e.ho));
      chk("conflict", stp, 32'(cf_a),  32'(e.cf));
      chk("sticky",   stp, 32'(st_a),  32'(e.st));
      chk("count",    stp, 32'(cnt_a), 32'(e.cnt));
      if (e.chk_b) begin
         chk("Q_b",     stp, 32'(q_b), 32'(e.qb));
         chk("owner_b", stp, 32'(o_b), 32'(e.ob));
         chk("valid_b", stp, 32'(v_b), 32'(e.v));
      end
   endtask

   initial begin
      Reset = 1'b1; gate = 4'b0000; clear_err = 1'b0;
      pc = 16'h3001; mdr = 16'hBEEF; mar = 16'h3000; alu = 16'hA1A1;
      @(negedge Clk);

      // reset with all gates asserted: no conflict pulse
      step(1,  1'b1, 4'b1111, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h0000, 2'd0);
      step(2,  1'b1, 4'b1111, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h0000, 2'd0);
      step(3,  1'b0, 4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h3001, 2'd0);
      // one-hot walk
      step(4,  1'b0, 4'b0001, 1'b0, 16'h3001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h3001, 2'd0);
      step(5,  1'b0, 4'b0010, 1'b0, 16'hBEEF, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 16'hBEEF, 2'd1);
      step(6,  1'b0, 4'b0100, 1'b0, 16'h3000, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 16'h3000, 2'd2);
      step(7,  1'b0, 4'b1000, 1'b0, 16'hA1A1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 16'hA1A1, 2'd3);
      // idle hold vs. default-source load
      step(8,  1'b0, 4'b0010, 1'b0, 16'hBEEF, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 16'hBEEF, 2'd1);
      mdr = 16'h1234;
      for (int k = 0; k < 3; k++)
         step(9 + k, 1'b0, 4'b0000, 1'b0, 16'hBEEF, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h3001, 2'd0);
      mdr = 16'hBEEF;
      // conflicts: lowest index wins, count saturates at 3 on dut_a
      step(12, 1'b0, 4'b0110, 1'b0, 16'hBEEF, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 16'hBEEF, 2'd1);
      step(13, 1'b0, 4'b1100, 1'b0, 16'h3000, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 16'h3000, 2'd2);
      step(14, 1'b0, 4'b1111, 1'b0, 16'h3001, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd0);
      step(15, 1'b0, 4'b1111, 1'b0, 16'h3001, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd0);
      step(16, 1'b0, 4'b1111, 1'b0, 16'h3001, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 16'h0000, 2'd0);
      chk("count_b_no_sat", 16, 32'(cnt_b), 32'd5);
      // clear alone, then clear together with a conflict
      step(17, 1'b0, 4'b0000, 1'b1, 16'h3001, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h3001, 2'd0);
      step(18, 1'b0, 4'b0011, 1'b1, 16'h3001, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 16'h3001, 2'd0);
      step(19, 1'b0, 4'b0000, 1'b0, 16'h3001, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000, 2'd0);
      // idle gap between owners gives no handover
      step(20, 1'b0, 4'b0001, 1'b0, 16'h3001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000, 2'd0);
      step(21, 1'b0, 4'b0000, 1'b0, 16'h3001, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 16'h0000, 2'd0);
      step(22, 1'b0, 4'b1000, 1'b0, 16'hA1A1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 16'hA1A1, 2'd3);
      step(23, 1'b0, 4'b0001, 1'b0, 16'h3001, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 16'h3001, 2'd0);
      // data tracks the held source
      pc = 16'h5555;
      step(24, 1'b0, 4'b0001, 1'b0, 16'h5555, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 16'h5555, 2'd0);
      // mid-operation reset, then normal evaluation on the first edge after
      step(25, 1'b1, 4'b0100, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h0000, 2'd0);
      step(26, 1'b0, 4'b0100, 1'b0, 16'h3000, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h3000, 2'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
